// File: rtl/flux_rr_merger_if.sv
// rtl/flux_rr_merger_if.sv - producer channels and tagged FIFO write port of flux_rr_merger
interface flux_rr_merger_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2
) ();
  localparam int IDW = $clog2(FLUX);

  logic [FLUX*DATA_WIDTH-1:0]  in_data;
  logic [FLUX-1:0]             in_valid;
  logic [FLUX-1:0]             in_ready;
  logic [DATA_WIDTH+IDW-1:0]   din;
  logic                        write;
  logic [FLUX-1:0]             full;

  modport master (
    output in_data, in_valid, full,
    input  in_ready, din, write
  );

  modport slave (
    input  in_data, in_valid, full,
    output in_ready, din, write
  );
endinterface

// File: rtl/flux_rr_merger.sv
// rtl/flux_rr_merger.sv - round-robin bounded-burst merger of FLUX channels into a tagged FIFO port
// Optional per-flux beat and stall counters when FLUX_RR_MERGER_STATS_EN is defined.
module flux_rr_merger #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int BURST      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  flux_rr_merger_if.slave      bus
`ifdef FLUX_RR_MERGER_STATS_EN
  ,
  output logic [FLUX*16-1:0]   beat_count,
  output logic [15:0]          stall_count
`endif
);
  localparam int IDW = $clog2(FLUX);
  localparam int CW  = $clog2(BURST + 1);
  localparam logic [CW-1:0]  BURST_C = CW'(BURST);
  localparam logic [IDW-1:0] LAST_ID = IDW'(FLUX - 1);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         lock_id_q, lock_id_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]          beat_cnt_q, beat_cnt_d;

  logic [FLUX-1:0]        elig;
  logic                   grant_vld;
  logic                   continuing;
  logic [IDW-1:0]         grant_id;
  logic [IDW-1:0]         cand;
  logic [DATA_WIDTH-1:0]  payload;
  logic                   write_en;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= FLUX) s = s - FLUX;
    return IDW'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OPEN;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    elig       = bus.in_valid & ~bus.full;
    grant_vld  = 1'b0;
    grant_id   = '0;
    cand       = '0;
    payload    = '0;
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    ptr_d      = ptr_q;

    // An open burst keeps the grant only while its owner stays eligible.
    continuing = (state_q == ST_LOCKED) && elig[lock_id_q];
    if (continuing) begin
      grant_vld = 1'b1;
      grant_id  = lock_id_q;
    end else begin
      for (int k = 0; k < FLUX; k++) begin
        cand = wrap_add(ptr_q, k);
        if (!grant_vld && elig[cand]) begin
          grant_vld = 1'b1;
          grant_id  = cand;
        end
      end
    end

    for (int k = 0; k < FLUX; k++) begin
      if (grant_id == IDW'(k)) payload = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    if (grant_vld) begin
      if (continuing) begin
        beat_cnt_d = beat_cnt_q + CW'(1);
      end else begin
        beat_cnt_d = CW'(1);
        lock_id_d  = grant_id;
        ptr_d      = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
      end
      state_d = (beat_cnt_d < BURST_C) ? ST_LOCKED : ST_OPEN;
    end else if (state_q == ST_LOCKED) begin
      state_d = ST_OPEN;
    end

    write_en     = grant_vld && !rst;
    bus.write    = write_en;
    bus.in_ready = write_en ? (FLUX'(1) << grant_id) : '0;
    bus.din      = write_en ? {grant_id, payload} : '0;
  end

`ifdef FLUX_RR_MERGER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      for (int k = 0; k < FLUX; k++) begin
        if (write_en && grant_id == IDW'(k))
          beat_count[k*16 +: 16] <= beat_count[k*16 +: 16] + 16'd1;
      end
      if ((|bus.in_valid) && !write_en) stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule
